// File: rtl/data_memory_arbiter_if.sv
// Requester, completion and data-memory signals shared by the arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface data_memory_arbiter_if;
  logic        m0_req;
  logic        m0_write;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic        m0_err;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_write;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic        m1_err;
  logic [31:0] m1_rdata;

  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_readData;

  modport slave (
    input  m0_req,
    input  m0_write,
    input  m0_addr,
    input  m0_wdata,
    output m0_ack,
    output m0_err,
    output m0_rdata,
    input  m1_req,
    input  m1_write,
    input  m1_addr,
    input  m1_wdata,
    output m1_ack,
    output m1_err,
    output m1_rdata,
    output mem_address,
    output mem_writeData,
    output mem_read,
    output mem_write,
    input  mem_readData
  );

  modport master (
    output m0_req,
    output m0_write,
    output m0_addr,
    output m0_wdata,
    input  m0_ack,
    input  m0_err,
    input  m0_rdata,
    output m1_req,
    output m1_write,
    output m1_addr,
    output m1_wdata,
    input  m1_ack,
    input  m1_err,
    input  m1_rdata,
    input  mem_address,
    input  mem_writeData,
    input  mem_read,
    input  mem_write,
    output mem_readData
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-master arbiter in front of a single-ported data memory.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin, else m0 has fixed priority.
module data_memory_arbiter #(
  parameter int DEPTH = 2010
) (
  input logic                  clk,
  input logic                  rst,
  data_memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  localparam logic [31:0] LP_DEPTH = 32'(DEPTH);

  state_t      r_state;
  state_t      w_next;

  logic        r_grant;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        r_ack0;
  logic        r_ack1;
  logic        r_err0;
  logic        r_err1;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic        w_any;
  logic        w_sel;
  logic        w_take;
  logic        w_in_range;
  logic        w_done;
  logic [31:0] w_load;

  logic [31:0] w_mem_address;
  logic [31:0] w_mem_wdata;
  logic        w_mem_read;
  logic        w_mem_write;

  assign w_any      = bus.m0_req | bus.m1_req;
  assign w_take     = (r_state == S_IDLE) & w_any;
  assign w_in_range = (r_addr < LP_DEPTH);
  assign w_done     = (r_state == S_ACCESS);
  assign w_load     = w_in_range ? bus.mem_readData : 32'h0;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic r_last;

  // On contention the master that did not win last time goes first
  always_comb begin
    w_sel = 1'b0;
    unique case (1'b1)
      bus.m0_req & bus.m1_req:  w_sel = ~r_last;
      ~bus.m0_req & bus.m1_req: w_sel = 1'b1;
      default:                  w_sel = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_take) begin
      r_last <= w_sel;
    end
  end
`else
  assign w_sel = ~bus.m0_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   w_next = w_any ? S_ACCESS : S_IDLE;
      S_ACCESS: w_next = S_ACK;
      S_ACK:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_address = 32'h0;
    w_mem_wdata   = 32'h0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    if (r_state == S_ACCESS) begin
      w_mem_address = r_addr;
      w_mem_wdata   = r_wdata;
      w_mem_read    = w_in_range & ~r_write;
      w_mem_write   = w_in_range & r_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
    end else if (w_take) begin
      r_grant <= w_sel;
      r_write <= w_sel ? bus.m1_write : bus.m0_write;
      r_addr  <= w_sel ? bus.m1_addr  : bus.m0_addr;
      r_wdata <= w_sel ? bus.m1_wdata : bus.m0_wdata;
    end
  end

  // Ack/err are registered so they appear in the ACK cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= 32'h0;
      r_rdata1 <= 32'h0;
    end else begin
      r_ack0 <= w_done & ~r_grant;
      r_ack1 <= w_done & r_grant;
      r_err0 <= w_done & ~r_grant & ~w_in_range;
      r_err1 <= w_done & r_grant & ~w_in_range;
      if (w_done & ~r_write & ~r_grant) begin
        r_rdata0 <= w_load;
      end
      if (w_done & ~r_write & r_grant) begin
        r_rdata1 <= w_load;
      end
    end
  end

  assign bus.m0_ack        = r_ack0;
  assign bus.m1_ack        = r_ack1;
  assign bus.m0_err        = r_err0;
  assign bus.m1_err        = r_err1;
  assign bus.m0_rdata      = r_rdata0;
  assign bus.m1_rdata      = r_rdata1;
  assign bus.mem_address   = w_mem_address;
  assign bus.mem_writeData = w_mem_wdata;
  assign bus.mem_read      = w_mem_read;
  assign bus.mem_write     = w_mem_write;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: transaction-level model of grants,
// memory contents and per-cycle outputs, with a behavioural memory.
module tb_data_memory_arbiter;
  localparam int DEPTH = 2010;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;

  int n_vec = 0;
  int n_err = 0;
  int m_last = 1;

  op_t q0[$];
  op_t q1[$];

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];

  always #5 clk = ~clk;

  data_memory_arbiter_if bus ();

  data_memory_arbiter #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (bus.mem_write && bus.mem_address < DEPTH) begin
      mem[bus.mem_address[10:0]] <= bus.mem_writeData;
    end
  end

  assign bus.mem_readData = (bus.mem_address < DEPTH) ?
                            mem[bus.mem_address[10:0]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int m);
    if (m == 0) begin
      bus.m0_req = (q0.size() > 0);
      if (q0.size() > 0) begin
        bus.m0_write = q0[0].wr;
        bus.m0_addr  = q0[0].addr;
        bus.m0_wdata = q0[0].data;
      end
    end else begin
      bus.m1_req = (q1.size() > 0);
      if (q1.size() > 0) begin
        bus.m1_write = q1[0].wr;
        bus.m1_addr  = q1[0].addr;
        bus.m1_wdata = q1[0].data;
      end
    end
  endtask

  function automatic op_t mk(input logic wr, input logic [31:0] a,
                             input logic [31:0] d);
    op_t o;
    o.wr = wr;
    o.addr = a;
    o.data = d;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int r;
    o.wr = 1'($urandom_range(0, 1));
    o.data = $urandom();
    r = $urandom_range(0, 19);
    if (r < 16) o.addr = 32'(r);
    else if (r == 16) o.addr = 32'd2009;
    else if (r == 17) o.addr = 32'd2010;
    else if (r == 18) o.addr = 32'hFFFF_FFFF;
    else o.addr = $urandom() | 32'h8000_0000;
    return o;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_m0_ack"}, bus.m0_ack, 0);
    chk({tag, "_m1_ack"}, bus.m1_ack, 0);
    chk({tag, "_m0_err"}, bus.m0_err, 0);
    chk({tag, "_m1_err"}, bus.m1_err, 0);
    chk({tag, "_m0_rdata"}, bus.m0_rdata, 0);
    chk({tag, "_m1_rdata"}, bus.m1_rdata, 0);
    chk({tag, "_mem_addr"}, bus.mem_address, 0);
    chk({tag, "_mem_wdata"}, bus.mem_writeData, 0);
    chk({tag, "_mem_read"}, bus.mem_read, 0);
    chk({tag, "_mem_write"}, bus.mem_write, 0);
  endtask

  // Every grant slot is 3 cycles; both queues stay pending until drained.
  task automatic run_round();
    int who[$];
    op_t eop[$];
    logic [31:0] erd[$];
    op_t c0[$];
    op_t c1[$];
    op_t o;
    int w, n, k, ph;
    logic [31:0] rd;
    logic in_r, act, ackc;
    c0 = q0;
    c1 = q1;
    while (c0.size() + c1.size() > 0) begin
      if (c0.size() > 0 && c1.size() > 0) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        w = (m_last == 0) ? 1 : 0;
`else
        w = 0;
`endif
      end else begin
        w = (c0.size() > 0) ? 0 : 1;
      end
      m_last = w;
      o = (w == 1) ? c1.pop_front() : c0.pop_front();
      rd = 32'h0;
      if (o.addr < DEPTH) begin
        if (o.wr) ref_mem[o.addr[10:0]] = o.data;
        else rd = ref_mem[o.addr[10:0]];
      end
      who.push_back(w);
      eop.push_back(o);
      erd.push_back(rd);
    end
    n = who.size();
    drive(0);
    drive(1);
    for (int c = 1; c <= 3 * n + 2; c++) begin
      @(negedge clk);
      k = (c - 1) / 3;
      ph = (c - 1) % 3;
      o = '0;
      in_r = 1'b0;
      w = -1;
      if (k < n) begin
        o = eop[k];
        in_r = (o.addr < DEPTH);
        w = who[k];
      end
      act = (k < n) && (ph == 0);
      ackc = (k < n) && (ph == 1);
      chk("m0_ack", bus.m0_ack, ackc && w == 0);
      chk("m1_ack", bus.m1_ack, ackc && w == 1);
      chk("mem_read", bus.mem_read, act && in_r && !o.wr);
      chk("mem_write", bus.mem_write, act && in_r && o.wr);
      chk("mem_addr", bus.mem_address, act ? o.addr : 32'h0);
      chk("mem_wdata", bus.mem_writeData, act ? o.data : 32'h0);
      if (ackc && w == 0) begin
        chk("m0_err", bus.m0_err, !in_r);
        if (!o.wr) chk("m0_rdata", bus.m0_rdata, erd[k]);
      end
      if (ackc && w == 1) begin
        chk("m1_err", bus.m1_err, !in_r);
        if (!o.wr) chk("m1_rdata", bus.m1_rdata, erd[k]);
      end
      if (bus.m0_ack && q0.size() > 0) begin
        void'(q0.pop_front());
        drive(0);
      end
      if (bus.m1_ack && q1.size() > 0) begin
        void'(q1.pop_front());
        drive(1);
      end
    end
    q0.delete();
    q1.delete();
    drive(0);
    drive(1);
  endtask

  initial begin
    bus.m0_req = 1'b0;
    bus.m0_write = 1'b0;
    bus.m0_addr = 32'h0;
    bus.m0_wdata = 32'h0;
    bus.m1_req = 1'b0;
    bus.m1_write = 1'b0;
    bus.m1_addr = 32'h0;
    bus.m1_wdata = 32'h0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    rst = 1'b1;
    mem_clr = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    mem_clr = 1'b0;
    @(negedge clk);
    chk_reset_vals("post_reset");

    q0.push_back(mk(1'b1, 32'd3, 32'h1111_0003));
    q0.push_back(mk(1'b0, 32'd3, 32'h0));
    q1.push_back(mk(1'b1, 32'd4, 32'h2222_0004));
    q1.push_back(mk(1'b0, 32'd3, 32'h0));
    run_round();

    q0.push_back(mk(1'b1, 32'd5, 32'hDEAD_BEEF));
    q0.push_back(mk(1'b0, 32'd5, 32'h0));
    run_round();

    q1.push_back(mk(1'b0, 32'd2010, 32'h0));
    q1.push_back(mk(1'b1, 32'hFFFF_FFFF, 32'hBAD0_BAD0));
    q1.push_back(mk(1'b0, 32'd2009, 32'h0));
    run_round();

    q0.push_back(mk(1'b1, 32'd9, 32'h0909_0909));
    q0.push_back(mk(1'b0, 32'd9, 32'h0));
    q0.push_back(mk(1'b0, 32'd5, 32'h0));
    run_round();

    for (int r = 0; r < 30; r++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      for (int i = 0; i < n0; i++) q0.push_back(rand_op());
      for (int i = 0; i < n1; i++) q1.push_back(rand_op());
      run_round();
    end

    bus.m0_req = 1'b1;
    bus.m0_write = 1'b1;
    bus.m0_addr = 32'd7;
    bus.m0_wdata = 32'h7777_ABCD;
    @(negedge clk);
    chk("rst_acc_write", bus.mem_write, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.m0_req = 1'b0;
    chk_reset_vals("rst_in_access");
    chk("rst_mem7", mem[7], 32'h7777_ABCD);
    ref_mem[7] = 32'h7777_ABCD;
    m_last = 1;
    @(negedge clk);
    chk("rst_no_ack0", bus.m0_ack, 0);
    chk("rst_no_ack1", bus.m1_ack, 0);

    q0.push_back(mk(1'b0, 32'd7, 32'h0));
    q1.push_back(mk(1'b0, 32'd5, 32'h0));
    run_round();

    for (int a = 0; a < 16; a++) chk("mem_final", mem[a], ref_mem[a]);
    chk("mem_final_top", mem[DEPTH-1], ref_mem[DEPTH-1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter that shares the single-ported data memory between two requesters: master 0 (core load/store path) and master 1 (debug/DMA loader). It serialises accesses with a req/ack handshake, drives the memory's address, write-data, read and write strobes, registers read data, and rejects out-of-range word addresses. It sits between the requesters and the data memory instance, which has a combinational read and a write on the rising clock edge.

## Interface
- `DEPTH`, 2010: memory depth in 32-bit words; legal word addresses are 0..DEPTH-1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `m0_req`, `m1_req`  in  1: access request; held high until the matching ack.
- `m0_write`, `m1_write`  in  1: 1 = store, 0 = load; stable while req is high.
- `m0_addr`, `m1_addr`  in  32: word address; stable while req is high.
- `m0_wdata`, `m1_wdata`  in  32: store data; stable while req is high.
- `m0_ack`, `m1_ack`  out  1: one-cycle completion pulse.
- `m0_err`, `m1_err`  out  1: valid with ack; 1 = address out of range.
- `m0_rdata`, `m1_rdata`  out  32: load data; valid with ack, held until the next ack to the same master.
- `mem_address`  out  32: to the memory's `address` input.
- `mem_writeData`  out  32: to the memory's `writeData` input.
- `mem_read`, `mem_write`  out  1: memory strobes.
- `mem_readData`  in  32: from the memory's `readData` output.

## Operation
- FSM states: IDLE, ACCESS, ACK. Reset state: IDLE.
- IDLE:
  - If any req is high, select a winner, latch `grant` (0/1) together with the winner's write, addr and wdata, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (exactly one cycle):
  - `mem_address` = latched addr.
  - `mem_writeData` = latched wdata.
  - If addr < DEPTH: `mem_write` = latched write and `mem_read` = !latched write.
  - If addr ≥ DEPTH: both strobes stay 0 and the err flag is latched.
  - On the closing edge a load captures `mem_readData` into the granted master's rdata register; a store commits inside the memory.
  - Next state: ACK.
- ACK: pulse the granted master's ack with its err flag, then return to IDLE. The master may drop req in the same cycle or keep it high to issue a new request.
- Arbitration:
  - Round-robin using a `last` register, which resets to 1 so master 0 wins first.
  - When both reqs are high, the master other than `last` wins, and `last` updates on grant.
  - When only one req is high, that master wins.
- Out-of-range load: rdata = 32'h0, err = 1. Out-of-range store: memory is untouched, err = 1.
- Outside ACCESS: `mem_read` and `mem_write` are 0, and `mem_address` and `mem_writeData` are 0.

## Timing
- Request sampled at edge k (state IDLE) → ACCESS in cycle k..k+1 → ack high in cycle k+1..k+2. Fixed 3 cycles from IDLE sample to IDLE again.
- Peak throughput: one access per 3 cycles.
- Strobes are decoded combinationally from state and latched fields, with no memory-side glitches within a cycle.
- Reset values:
  - FSM state = IDLE, `last` = 1, `grant` = 0.
  - Both acks and both errs = 0.
  - Both rdata = 32'h0.
  - All `mem_*` outputs = 0.
- Reset asserted while in ACCESS: a store on that edge still commits in memory (the memory has no reset), but no ack is issued. The requester must reissue.
- Reset asserted while in ACK: the ack for that cycle is still visible (it is a registered output), and the state returns to IDLE.
- Req dropped before ack is a protocol violation and the outcome is undefined. Req raised during ACCESS/ACK waits for the next IDLE.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN`:
  - Defined: round-robin arbitration as described above.
  - Undefined: fixed priority, where master 0 always wins when both reqs are high and the `last` register is not implemented. Master 1 can starve under continuous master-0 traffic.

## Test plan
- m0 store addr 5, data 32'hDEADBEEF, then m0 load addr 5 → first ack after 2 cycles with err=0. Second ack has rdata=32'hDEADBEEF, and `mem_write` was high for exactly one cycle.
- m0 and m1 both req at the same edge, both held high for 4 accesses → grants alternate m0, m1, m0, m1 with round-robin defined. Without the macro all grants go to m0.
- m1 load addr 2010 → `m1_err`=1, `m1_rdata`=0, `mem_read` never asserted. m1 store addr 32'hFFFFFFFF → err=1 and memory contents unchanged.
- `rst` pulsed during ACCESS of an m0 store to addr 7 → no `m0_ack`, all outputs return to reset values next cycle, and memory[7] holds the new data.
- m0 keeps req high through its ack with m1 idle → back-to-back m0 accesses every 3 cycles, and `m1_ack` stays 0 throughout.
